// File: rtl/param_intc_pkg.sv
// Shared constants, register-select type and address decoder for the
// parametrised interrupt controller.
package param_intc_pkg;

    localparam int ID_W = 5;

    localparam logic [4:0] ADDR_PENDING   = 5'd0;
    localparam logic [4:0] ADDR_MODE      = 5'd1;
    localparam logic [4:0] ADDR_ISR       = 5'd2;
    localparam logic [4:0] ADDR_MASK      = 5'd3;
    localparam logic [4:0] ADDR_THRESHOLD = 5'd4;
    localparam logic [4:0] ADDR_CLAIM     = 5'd5;
    localparam logic [4:0] ADDR_PRIO_BASE = 5'd8;

    typedef enum logic [2:0] {
        SEL_PENDING,
        SEL_MODE,
        SEL_ISR,
        SEL_MASK,
        SEL_THRESHOLD,
        SEL_CLAIM,
        SEL_PRIO,
        SEL_NONE
    } reg_sel_e;

    // Anything past the last priority slot (and the gap at 6..7) is undecoded.
    function automatic reg_sel_e decode_addr(input logic [4:0] addr, input int num_irq);
        case (addr)
            ADDR_PENDING:   return SEL_PENDING;
            ADDR_MODE:      return SEL_MODE;
            ADDR_ISR:       return SEL_ISR;
            ADDR_MASK:      return SEL_MASK;
            ADDR_THRESHOLD: return SEL_THRESHOLD;
            ADDR_CLAIM:     return SEL_CLAIM;
            default: begin
                if (addr >= ADDR_PRIO_BASE &&
                    32'(addr) < 32'(ADDR_PRIO_BASE) + 32'(num_irq))
                    return SEL_PRIO;
                return SEL_NONE;
            end
        endcase
    endfunction

endpackage

// File: rtl/intc_prio_arbiter.sv
// Combinational winner selection: highest priority candidate above both the
// threshold and the current in-service priority, lowest index on ties.
module intc_prio_arbiter
    import param_intc_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int PRIO_W  = 3
) (
    input  logic [NUM_IRQ-1:0]        i_cand,
    input  logic [NUM_IRQ*PRIO_W-1:0] i_prio,
    input  logic [PRIO_W-1:0]         i_threshold,
    input  logic [NUM_IRQ-1:0]        i_isr,
    output logic                      o_valid,
    output logic [ID_W-1:0]           o_id
);

    logic [PRIO_W-1:0] w_isr_prio;
    logic [PRIO_W-1:0] w_floor;
    logic [PRIO_W-1:0] w_best;

    // The floor is never below zero, so a priority-0 channel can never win.
    always_comb begin
        w_isr_prio = '0;
        for (int n = 0; n < NUM_IRQ; n++) begin
            if (i_isr[n] && i_prio[n*PRIO_W +: PRIO_W] > w_isr_prio)
                w_isr_prio = i_prio[n*PRIO_W +: PRIO_W];
        end
        w_floor = (i_threshold > w_isr_prio) ? i_threshold : w_isr_prio;

        o_valid = 1'b0;
        o_id    = '0;
        w_best  = '0;
        for (int n = 0; n < NUM_IRQ; n++) begin
            if (i_cand[n] && i_prio[n*PRIO_W +: PRIO_W] > w_floor &&
                (!o_valid || i_prio[n*PRIO_W +: PRIO_W] > w_best)) begin
                o_valid = 1'b1;
                o_id    = ID_W'(n);
                w_best  = i_prio[n*PRIO_W +: PRIO_W];
            end
        end
    end

endmodule

// File: rtl/param_interrupt_controller.sv
// APB-programmable interrupt controller with per-channel edge/level capture,
// masking, priority threshold and nested claim/complete handling.
module param_interrupt_controller
    import param_intc_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int PRIO_W  = 3
) (
    input  logic               pclk_i,
    input  logic               rst_i,
    input  logic               psel_i,
    input  logic               penable_i,
    input  logic               pwrite_i,
    input  logic [31:0]        paddr_i,
    input  logic [31:0]        pwdata_i,
    output logic [31:0]        prdata_o,
    output logic               pready_o,
    output logic               pslverr_o,
    input  logic [NUM_IRQ-1:0] irq_trigger_i,
    input  logic               enable_i,
    output logic               irq_o,
    output logic [ID_W-1:0]    irq_id_o
);

    logic [NUM_IRQ-1:0] r_pending, r_mode, r_isr, r_mask, r_trig_d;
    logic [PRIO_W-1:0]  r_threshold;
    logic [PRIO_W-1:0]  r_prio [NUM_IRQ];
    logic               r_irq;
    logic [ID_W-1:0]    r_irq_id;

    logic                      w_access, w_wr, w_rd, w_claim;
    reg_sel_e                  w_sel;
    logic [ID_W-1:0]           w_prio_idx;
    logic [NUM_IRQ*PRIO_W-1:0] w_prio_flat;
    logic                      w_win_valid;
    logic [ID_W-1:0]           w_win_id;
    logic [NUM_IRQ-1:0]        w_win_onehot, w_edge, w_set, w_clr;
    logic [NUM_IRQ-1:0]        w_pending_next, w_isr_next;
    logic [31:0]               w_rdata;
    logic                      w_unused_addr;

    // Reset aborts any transfer in flight, so access qualifies on ~rst_i.
    assign w_access      = psel_i & penable_i & ~rst_i;
    assign w_wr          = w_access & pwrite_i;
    assign w_rd          = w_access & ~pwrite_i;
    assign w_sel         = decode_addr(paddr_i[4:0], NUM_IRQ);
    assign w_prio_idx    = paddr_i[4:0] - ADDR_PRIO_BASE;
    assign w_claim       = w_rd && (w_sel == SEL_CLAIM) && w_win_valid;
    assign w_unused_addr = |paddr_i[31:5];

    always_comb begin
        w_prio_flat  = '0;
        w_win_onehot = '0;
        for (int n = 0; n < NUM_IRQ; n++) begin
            w_prio_flat[n*PRIO_W +: PRIO_W] = r_prio[n];
            w_win_onehot[n] = w_win_valid && (w_win_id == ID_W'(n));
        end
    end

    intc_prio_arbiter #(
        .NUM_IRQ(NUM_IRQ),
        .PRIO_W (PRIO_W)
    ) u_arbiter (
        .i_cand     (r_pending & r_mask),
        .i_prio     (w_prio_flat),
        .i_threshold(r_threshold),
        .i_isr      (r_isr),
        .o_valid    (w_win_valid),
        .o_id       (w_win_id)
    );

    // New captures take precedence over a same-cycle W1C or claim clear.
    always_comb begin
        w_edge = irq_trigger_i & ~r_trig_d;
        w_set  = '0;
        if (enable_i)
            w_set = (r_mode & w_edge) | (~r_mode & irq_trigger_i);
        w_clr = '0;
        if (w_wr && w_sel == SEL_PENDING)
            w_clr = pwdata_i[NUM_IRQ-1:0];
        if (w_claim)
            w_clr = w_clr | w_win_onehot;
        w_pending_next = (r_pending & ~w_clr) | w_set;

        w_isr_next = r_isr;
        if (w_claim)
            w_isr_next = w_isr_next | w_win_onehot;
        if (w_wr && w_sel == SEL_CLAIM) begin
            for (int n = 0; n < NUM_IRQ; n++)
                if (pwdata_i == 32'(n)) w_isr_next[n] = 1'b0;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            case (w_sel)
                SEL_PENDING:   w_rdata[NUM_IRQ-1:0] = r_pending;
                SEL_MODE:      w_rdata[NUM_IRQ-1:0] = r_mode;
                SEL_ISR:       w_rdata[NUM_IRQ-1:0] = r_isr;
                SEL_MASK:      w_rdata[NUM_IRQ-1:0] = r_mask;
                SEL_THRESHOLD: w_rdata[PRIO_W-1:0]  = r_threshold;
                SEL_CLAIM: begin
                    if (w_win_valid) begin
                        w_rdata[31]       = 1'b1;
                        w_rdata[ID_W-1:0] = w_win_id;
                    end
                end
                SEL_PRIO: begin
                    for (int n = 0; n < NUM_IRQ; n++)
                        if (w_prio_idx == ID_W'(n)) w_rdata[PRIO_W-1:0] = r_prio[n];
                end
                default: w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge pclk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pending   <= '0;
            r_isr       <= '0;
            r_mask      <= '0;
            r_mode      <= '1;
            r_threshold <= '0;
            r_trig_d    <= '0;
            r_irq       <= 1'b0;
            r_irq_id    <= '0;
            for (int n = 0; n < NUM_IRQ; n++) r_prio[n] <= '0;
        end else begin
            r_trig_d  <= irq_trigger_i;
            r_pending <= w_pending_next;
            r_isr     <= w_isr_next;
            r_irq     <= w_win_valid;
            r_irq_id  <= w_win_valid ? w_win_id : '0;
            if (w_wr && w_sel == SEL_MODE)      r_mode      <= pwdata_i[NUM_IRQ-1:0];
            if (w_wr && w_sel == SEL_MASK)      r_mask      <= pwdata_i[NUM_IRQ-1:0];
            if (w_wr && w_sel == SEL_THRESHOLD) r_threshold <= pwdata_i[PRIO_W-1:0];
            for (int n = 0; n < NUM_IRQ; n++)
                if (w_wr && w_sel == SEL_PRIO && w_prio_idx == ID_W'(n))
                    r_prio[n] <= pwdata_i[PRIO_W-1:0];
        end
    end

    assign prdata_o  = w_rdata;
    assign pready_o  = 1'b1;
    assign pslverr_o = w_access && (w_sel == SEL_NONE);
    assign irq_o     = r_irq & enable_i;
    assign irq_id_o  = r_irq_id;

endmodule

// File: tb/tb_param_interrupt_controller.sv
// Directed self-checking bench for param_interrupt_controller with four
// channels, covering the threshold/mask/tie/nesting, level, error and reset cases.
module tb_param_interrupt_controller;

    logic        pclk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [3:0]  trig;
    logic        en;
    logic        irq;
    logic [4:0]  irqId;

    int          nCompared   = 0;
    int          nMismatched = 0;
    logic [31:0] rd;
    logic        err;

    param_interrupt_controller #(.NUM_IRQ(4), .PRIO_W(3)) dut (
        .pclk_i       (pclk),
        .rst_i        (rst),
        .psel_i       (psel),
        .penable_i    (penable),
        .pwrite_i     (pwrite),
        .paddr_i      (paddr),
        .pwdata_i     (pwdata),
        .prdata_o     (prdata),
        .pready_o     (pready),
        .pslverr_o    (pslverr),
        .irq_trigger_i(trig),
        .enable_i     (en),
        .irq_o        (irq),
        .irq_id_o     (irqId)
    );

    always #5 pclk = ~pclk;

    task automatic apbWrite(input logic [31:0] addr, input logic [31:0] data, output logic errOut);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
        @(negedge pclk);
        penable = 1'b1;
        #1 errOut = pslverr;
        @(posedge pclk);
        #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apbRead(input logic [31:0] addr, output logic [31:0] data, output logic errOut);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
        @(negedge pclk);
        penable = 1'b1;
        #1 data = prdata; errOut = pslverr;
        @(posedge pclk);
        #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] v);
        @(negedge pclk); trig = v;
        @(negedge pclk); trig = 4'b0000;
    endtask

    task automatic doReset();
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; trig = '0; en = 1'b1;
        repeat (2) @(posedge pclk);
        @(negedge pclk); rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        nCompared++; if (irq !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_irq: got %b want 0", irq); end
        nCompared++; if (irqId !== 5'd0) begin nMismatched++; $display("[TB] FAIL reset_irq_id: got %0d want 0", irqId); end
        nCompared++; if (prdata !== 32'd0) begin nMismatched++; $display("[TB] FAIL reset_prdata: got %h want 0", prdata); end
        nCompared++; if (pslverr !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_pslverr: got %b want 0", pslverr); end
        nCompared++; if (pready !== 1'b1) begin nMismatched++; $display("[TB] FAIL pready: got %b want 1", pready); end
        apbRead(32'd0, rd, err);
        nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_pending: got %h want 0", rd); end
        apbRead(32'd1, rd, err);
        nCompared++; if (rd !== 32'hF) begin nMismatched++; $display("[TB] FAIL reset_mode: got %h want f", rd); end
        apbRead(32'd3, rd, err);
        nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_mask: got %h want 0", rd); end
        apbRead(32'd9, rd, err);
        nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_prio1: got %h want 0", rd); end
    endtask

    task automatic test_mask_threshold();
        apbWrite(32'd8, 32'd1, err);
        apbWrite(32'd9, 32'd1, err);
        apbWrite(32'd10, 32'd3, err);
        apbWrite(32'd11, 32'd3, err);
        apbWrite(32'd4, 32'd2, err);
        apbWrite(32'd3, 32'b0010, err);
        nCompared++; if (err !== 1'b0) begin nMismatched++; $display("[TB] FAIL valid_write_err: got %b want 0", err); end
        pulse(4'b1111);
        repeat (2) @(posedge pclk); #1;
        nCompared++; if (irq !== 1'b0) begin nMismatched++; $display("[TB] FAIL below_threshold_irq: got %b want 0", irq); end
        apbRead(32'd0, rd, err);
        nCompared++; if (rd !== 32'hF) begin nMismatched++; $display("[TB] FAIL pending_all: got %h want f", rd); end
        apbRead(32'd10, rd, err);
        nCompared++; if (rd !== 32'd3) begin nMismatched++; $display("[TB] FAIL prio2_readback: got %h want 3", rd); end
    endtask

    task automatic test_tie();
        apbWrite(32'd3, 32'b1100, err);
        nCompared++; if (irq !== 1'b0) begin nMismatched++; $display("[TB] FAIL irq_latency: got %b want 0", irq); end
        @(posedge pclk); #1;
        nCompared++; if (irq !== 1'b1) begin nMismatched++; $display("[TB] FAIL tie_irq: got %b want 1", irq); end
        nCompared++; if (irqId !== 5'd2) begin nMismatched++; $display("[TB] FAIL tie_id: got %0d want 2", irqId); end
    endtask

    task automatic test_claim_nest();
        apbRead(32'd5, rd, err);
        nCompared++; if (rd !== 32'h80000002) begin nMismatched++; $display("[TB] FAIL claim2: got %h want 80000002", rd); end
        apbRead(32'd0, rd, err);
        nCompared++; if (rd !== 32'hB) begin nMismatched++; $display("[TB] FAIL claim_pending: got %h want b", rd); end
        apbRead(32'd2, rd, err);
        nCompared++; if (rd !== 32'h4) begin nMismatched++; $display("[TB] FAIL claim_isr: got %h want 4", rd); end
        nCompared++; if (irq !== 1'b0) begin nMismatched++; $display("[TB] FAIL equal_prio_blocked: got %b want 0", irq); end
        apbWrite(32'd5, 32'd6, err);
        apbRead(32'd2, rd, err);
        nCompared++; if (rd !== 32'h4) begin nMismatched++; $display("[TB] FAIL complete_out_of_range: got %h want 4", rd); end
        apbWrite(32'd5, 32'd2, err);
        @(posedge pclk); #1;
        nCompared++; if (irq !== 1'b1) begin nMismatched++; $display("[TB] FAIL complete_irq: got %b want 1", irq); end
        nCompared++; if (irqId !== 5'd3) begin nMismatched++; $display("[TB] FAIL complete_id: got %0d want 3", irqId); end
        apbRead(32'd5, rd, err);
        nCompared++; if (rd !== 32'h80000003) begin nMismatched++; $display("[TB] FAIL claim3: got %h want 80000003", rd); end
        apbRead(32'd5, rd, err);
        nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL empty_claim: got %h want 0", rd); end
        apbRead(32'd2, rd, err);
        nCompared++; if (rd !== 32'h8) begin nMismatched++; $display("[TB] FAIL empty_claim_isr: got %h want 8", rd); end
    endtask

    task automatic test_level();
        apbWrite(32'd1, 32'hE, err);
        @(negedge pclk); trig = 4'b0001;
        @(posedge pclk);
        apbWrite(32'd0, 32'h1, err);
        apbRead(32'd0, rd, err);
        nCompared++; if (rd !== 32'h1) begin nMismatched++; $display("[TB] FAIL level_w1c_held: got %h want 1", rd); end
        @(negedge pclk); trig = 4'b0000;
        apbRead(32'd0, rd, err);
        nCompared++; if (rd !== 32'h1) begin nMismatched++; $display("[TB] FAIL level_sticky: got %h want 1", rd); end
        apbWrite(32'd0, 32'h1, err);
        apbRead(32'd0, rd, err);
        nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL level_w1c_clear: got %h want 0", rd); end
    endtask

    task automatic test_edge_collision();
        pulse(4'b0010);
        apbRead(32'd0, rd, err);
        nCompared++; if (rd !== 32'h2) begin nMismatched++; $display("[TB] FAIL edge_capture: got %h want 2", rd); end
        apbWrite(32'd0, 32'h2, err);
        apbRead(32'd0, rd, err);
        nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL edge_w1c: got %h want 0", rd); end
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'd0; pwdata = 32'h2;
        @(negedge pclk);
        penable = 1'b1; trig = 4'b0010;
        @(posedge pclk);
        #1 psel = 1'b0; penable = 1'b0;
        @(negedge pclk); trig = 4'b0000;
        apbRead(32'd0, rd, err);
        nCompared++; if (rd !== 32'h2) begin nMismatched++; $display("[TB] FAIL edge_beats_w1c: got %h want 2", rd); end
    endtask

    task automatic test_slverr();
        apbWrite(32'd4, 32'd3, err);
        apbWrite(32'd3, 32'h5, err);
        apbRead(32'd20, rd, err);
        nCompared++; if (err !== 1'b1) begin nMismatched++; $display("[TB] FAIL rd20_err: got %b want 1", err); end
        nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL rd20_data: got %h want 0", rd); end
        apbWrite(32'd20, 32'hFFFFFFFF, err);
        nCompared++; if (err !== 1'b1) begin nMismatched++; $display("[TB] FAIL wr20_err: got %b want 1", err); end
        apbRead(32'd4, rd, err);
        nCompared++; if (rd !== 32'd3) begin nMismatched++; $display("[TB] FAIL wr20_threshold: got %h want 3", rd); end
        apbRead(32'd3, rd, err);
        nCompared++; if (rd !== 32'h5) begin nMismatched++; $display("[TB] FAIL wr20_mask: got %h want 5", rd); end
        apbRead(32'd0, rd, err);
        nCompared++; if (rd !== 32'h2) begin nMismatched++; $display("[TB] FAIL wr20_pending: got %h want 2", rd); end
        apbRead(32'd1, rd, err);
        nCompared++; if (rd !== 32'hE) begin nMismatched++; $display("[TB] FAIL wr20_mode: got %h want e", rd); end
        apbRead(32'd11, rd, err);
        nCompared++; if (err !== 1'b0) begin nMismatched++; $display("[TB] FAIL last_prio_err: got %b want 0", err); end
        apbRead(32'd12, rd, err);
        nCompared++; if (err !== 1'b1) begin nMismatched++; $display("[TB] FAIL past_prio_err: got %b want 1", err); end
        apbRead(32'd6, rd, err);
        nCompared++; if (err !== 1'b1) begin nMismatched++; $display("[TB] FAIL gap6_err: got %b want 1", err); end
    endtask

    task automatic test_enable();
        @(negedge pclk); en = 1'b0;
        apbWrite(32'd10, 32'd4, err);
        apbRead(32'd10, rd, err);
        nCompared++; if (rd !== 32'd4) begin nMismatched++; $display("[TB] FAIL disabled_apb: got %h want 4", rd); end
        pulse(4'b0100);
        apbRead(32'd0, rd, err);
        nCompared++; if (rd !== 32'h2) begin nMismatched++; $display("[TB] FAIL disabled_capture: got %h want 2", rd); end
        @(negedge pclk); en = 1'b1;
        pulse(4'b0100);
        repeat (2) @(posedge pclk); #1;
        nCompared++; if (irq !== 1'b1) begin nMismatched++; $display("[TB] FAIL enabled_irq: got %b want 1", irq); end
        nCompared++; if (irqId !== 5'd2) begin nMismatched++; $display("[TB] FAIL enabled_id: got %0d want 2", irqId); end
        @(negedge pclk); en = 1'b0;
        @(posedge pclk); #1;
        nCompared++; if (irq !== 1'b0) begin nMismatched++; $display("[TB] FAIL disabled_irq: got %b want 0", irq); end
        @(negedge pclk); en = 1'b1;
        @(posedge pclk); #1;
        nCompared++; if (irq !== 1'b1) begin nMismatched++; $display("[TB] FAIL reenabled_irq: got %b want 1", irq); end
    endtask

    task automatic test_async_reset();
        apbWrite(32'd8, 32'd2, err);
        apbWrite(32'd9, 32'd5, err);
        apbWrite(32'd3, 32'h3, err);
        pulse(4'b0001);
        repeat (2) @(posedge pclk); #1;
        nCompared++; if (irq !== 1'b1 || irqId !== 5'd0) begin nMismatched++; $display("[TB] FAIL nest_first: got irq=%b id=%0d want irq=1 id=0", irq, irqId); end
        apbRead(32'd5, rd, err);
        nCompared++; if (rd !== 32'h80000000) begin nMismatched++; $display("[TB] FAIL claim0: got %h want 80000000", rd); end
        pulse(4'b0010);
        repeat (2) @(posedge pclk); #1;
        nCompared++; if (irq !== 1'b1 || irqId !== 5'd1) begin nMismatched++; $display("[TB] FAIL nest_preempt: got irq=%b id=%0d want irq=1 id=1", irq, irqId); end
        apbRead(32'd2, rd, err);
        nCompared++; if (rd !== 32'h1) begin nMismatched++; $display("[TB] FAIL nest_isr: got %h want 1", rd); end
        @(negedge pclk); #1 rst = 1'b1;
        #1;
        nCompared++; if (irq !== 1'b0) begin nMismatched++; $display("[TB] FAIL async_irq: got %b want 0", irq); end
        nCompared++; if (irqId !== 5'd0) begin nMismatched++; $display("[TB] FAIL async_id: got %0d want 0", irqId); end
        @(negedge pclk); rst = 1'b0;
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'd3; pwdata = 32'hF;
        @(negedge pclk);
        penable = 1'b1;
        #1 rst = 1'b1;
        #1;
        nCompared++; if (pslverr !== 1'b0 || prdata !== 32'h0) begin nMismatched++; $display("[TB] FAIL abort_outputs: got err=%b data=%h want 0/0", pslverr, prdata); end
        @(posedge pclk);
        #1 psel = 1'b0; penable = 1'b0;
        @(negedge pclk); rst = 1'b0;
        apbRead(32'd3, rd, err);
        nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL abort_mask: got %h want 0", rd); end
        apbRead(32'd2, rd, err);
        nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL post_reset_isr: got %h want 0", rd); end
        apbRead(32'd0, rd, err);
        nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL post_reset_pending: got %h want 0", rd); end
        apbRead(32'd9, rd, err);
        nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL post_reset_prio1: got %h want 0", rd); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        doReset();
        test_reset();
        test_mask_threshold();
        test_tie();
        test_claim_nest();
        doReset();
        test_level();
        test_edge_collision();
        test_slverr();
        test_enable();
        doReset();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/param_interrupt_controller.md
PARAM_INTERRUPT_CONTROLLER -- requirements
Module: param_interrupt_controller

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of interrupt channels, legal range 2..16.
REQ-002 SHALL have parameter PRIO_W, default 3, width of each channel priority and of the threshold.
REQ-003 SHALL have port pclk_i, input, 1: single clock; all logic is rising-edge triggered.
REQ-004 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port psel_i, input, 1: APB select.
REQ-006 SHALL have port penable_i, input, 1: APB enable.
REQ-007 SHALL have port pwrite_i, input, 1: APB direction, 1 = write.
REQ-008 SHALL have port paddr_i, input, 32: APB word index; only bits [4:0] are decoded.
REQ-009 SHALL have port pwdata_i, input, 32: APB write data.
REQ-010 SHALL have port prdata_o, output, 32: APB read data.
REQ-011 SHALL have port pready_o, output, 1: tied to 1 (zero wait states).
REQ-012 SHALL have port pslverr_o, output, 1: error response for an undecoded address.
REQ-013 SHALL have port irq_trigger_i, input, NUM_IRQ: synchronous interrupt sources.
REQ-014 SHALL have port enable_i, input, 1: controller enable (clock-gating qualifier).
REQ-015 SHALL have port irq_o, output, 1: interrupt request to the CPU.
REQ-016 SHALL have port irq_id_o, output, 5: ID of the winning channel (0..NUM_IRQ-1), valid while irq_o=1.

Function
REQ-017 SHALL use this register map: 0 PENDING (R, W1C); 1 MODE (RW, bit=1 edge, 0 level); 2 ISR (R, in-service one-hot); 3 MASK (RW, bit=1 enabled); 4 THRESHOLD (RW, PRIO_W bits); 5 CLAIM (R = claim, W = complete); 8..8+NUM_IRQ-1 PRIORITY[n] (RW, PRIO_W bits).
REQ-018 SHALL perform APB writes on the access cycle (psel_i & penable_i & pwrite_i), with the register updating on that edge.
REQ-019 SHALL provide read data on prdata_o combinationally during the access cycle and drive prdata_o=0 otherwise.
REQ-020 SHALL assert pslverr_o only during an access cycle whose address is outside the map, and such a write SHALL be ignored.
REQ-021 SHALL, for an edge-mode channel, set PENDING[n] in the cycle after irq_trigger_i[n] rises (1-cycle registered edge detect).
REQ-022 SHALL, for a level-mode channel, set PENDING[n] while irq_trigger_i[n]=1, and a W1C write SHALL NOT clear it while the level persists.
REQ-023 SHALL, when enable_i=0, block new pending captures and force irq_o=0, while APB access remains fully functional.
REQ-024 SHALL select as winner the channel that is pending, masked-in, has PRIORITY > THRESHOLD, and has PRIORITY > the priority of the current in-service channel; ties go to the lowest index.
REQ-025 SHALL never let a channel with PRIORITY = 0 win.
REQ-026 SHALL register irq_o and irq_id_o, so they update one cycle after the winner changes.
REQ-027 SHALL, on an APB read of CLAIM, return the winner ID in bits [4:0] and bit 31=1, clear its PENDING bit, and set its ISR bit; with no winner, it SHALL return 0 with no side effect.
REQ-028 SHALL allow nesting: a higher-priority winner may be claimed while another is in service, and ISR may hold multiple bits.
REQ-029 SHALL, on a write of ID k to CLAIM, clear ISR[k]; writes with k >= NUM_IRQ or with ISR[k]=0 SHALL be ignored.
REQ-030 SHALL give an edge that arrives in the same cycle as a W1C or claim of the same bit priority: the bit SHALL remain set.
REQ-031 SHALL define the in-service priority as the maximum PRIORITY over the set ISR bits, or 0 when ISR=0.

Reset
REQ-032 SHALL, on rst_i, set PENDING, ISR, and MASK to 0, MODE to all-1 (edge), and THRESHOLD and all PRIORITY registers to 0, with irq_o=0, irq_id_o=0, prdata_o=0, pslverr_o=0.
REQ-033 SHALL, on rst_i asserted mid-transfer, abort the transfer with no register update; the edge detector history SHALL reset to 0.

Structure
REQ-034 SHALL place the address constants (ADDR_PENDING..ADDR_PRIO_BASE) and the ID width in the shared package param_intc_pkg.
REQ-035 SHALL implement the priority comparison tree in the sub-module intc_prio_arbiter (combinational, parametrised by NUM_IRQ and PRIO_W).

Verification
REQ-036 SHALL verify: PRIORITY = {1,1,3,3}, THRESHOLD = 2, MASK = 4'b0010, pulse 4'b1111 -> irq_o stays 0; PENDING reads 4'b1111.
REQ-037 SHALL verify: same setup, then MASK = 4'b1100 -> irq_o=1 and irq_id_o=2 (tie goes to the lower index) one cycle after the write.
REQ-038 SHALL verify: claim -> read returns 0x80000002, PENDING=4'b1011, ISR=4'b0100, irq_id_o switches to 3? No: PRIORITY[3]=3 is not greater than in-service 3 -> irq_o=0; write 2 to CLAIM -> irq_o=1, irq_id_o=3.
REQ-039 SHALL verify: channel 0 in level mode with trigger held at 1 -> a W1C of bit 0 leaves PENDING[0]=1; after the trigger drops, a W1C clears it.
REQ-040 SHALL verify: a read of address 20 -> pslverr_o=1 and prdata_o=0; a write to address 20 changes no register.
REQ-041 SHALL verify: rst_i asserted while irq_o=1 and ISR is nonzero -> all outputs and registers return to reset values asynchronously, before the next pclk_i edge.
